// File: rtl/aes128_key_expander.sv
// AES-128 key schedule: expands one cipher key into round keys 0..10 held in a key store.
// Latency: key accepted at edge T, rk[1..10] written on edges T+1..T+10, keys_valid high after T+10.
// Backpressure: key_ready is high only in IDLE; key_valid while busy is ignored (no queueing).
// Optional build macro AES_KS_EQINV_EN: store rk[1..9] as InvMixColumns(rk) for the equivalent inverse cipher.
module aes128_key_expander #(
    parameter int NR     = 10,
    parameter bit RD_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    // Only the 10-round AES-128 schedule is implemented.
    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes128_key_expander: NR must be 10 (AES-128)");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers (polynomial x^8 + x^4 + x^3 + x + 1)
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (x^254, with 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] s;
        sq  = x;
        inv = 8'h01;
        // sq walks x^2, x^4 ... x^128; their product is x^254
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One key-schedule step: four new words from the previous four.
    function automatic logic [127:0] next_work(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h0};
        n0 = w[127:96] ^ t;
        n1 = w[95:64]  ^ n0;
        n2 = w[63:32]  ^ n1;
        n3 = w[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

`ifdef AES_KS_EQINV_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] k);
        return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
                inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_work;
    logic [3:0]     r_rnd;
    logic [7:0]     r_rcon;
    logic           r_keys_vld;
    logic [127:0]   r_rk [0:NR];

    logic           w_key_ready;
    logic           w_accept;
    logic           w_last;
    logic [127:0]   w_next;
    logic [127:0]   w_stored;
    logic [127:0]   w_rd_dat;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_key_ready = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_key_ready = 1'b1;
                if (key_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (r_rnd == 4'(NR)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next round key from the raw working key; the stored form may be transformed.
    always_comb begin
        w_next = next_work(r_work, r_rcon);
`ifdef AES_KS_EQINV_EN
        // The final round key stays raw; middle rounds feed the equivalent inverse cipher.
        w_stored = (r_rnd == 4'(NR)) ? w_next : inv_mix_columns(w_next);
`else
        w_stored = w_next;
`endif
    end

    // Key-schedule datapath and key store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_rnd      <= '0;
            r_rcon     <= 8'h01;
            r_keys_vld <= 1'b0;
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else if (w_accept) begin
            r_rk[0]    <= key;
            r_work     <= key;
            r_rnd      <= 4'd1;
            r_rcon     <= 8'h01;
            r_keys_vld <= 1'b0;
        end else if (r_state == S_EXPAND) begin
            r_work <= w_next;
            for (int i = 1; i <= NR; i++) begin
                if (r_rnd == 4'(i)) r_rk[i] <= w_stored;
            end
            r_rnd  <= r_rnd + 4'd1;
            r_rcon <= gf_xtime(r_rcon);
            if (w_last) r_keys_vld <= 1'b1;
        end
    end

    // Read mux; out-of-range indices return zero.
    always_comb begin
        w_rd_dat = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_addr == 4'(i)) w_rd_dat = r_rk[i];
        end
    end

    generate
        if (RD_REG) begin : g_rd_reg
            logic [127:0] r_rd_dat;
            // Registered read port: one edge of read latency, old data on a same-edge write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_rd_dat <= '0;
                else        r_rd_dat <= w_rd_dat;
            end
            assign rk_data = r_rd_dat;
        end else begin : g_rd_comb
            assign rk_data = w_rd_dat;
        end
    endgenerate

    assign key_ready  = w_key_ready;
    assign keys_valid = r_keys_vld;

endmodule

// File: tb/tb_aes128_key_expander.sv
module tb_aes128_key_expander;

    localparam bit RD_REG_TB = 1'b1;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int n_chk;
    int n_pass;

    logic [127:0] sb_q [$];
    logic [127:0] fips_rk [0:10];

    localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes128_key_expander #(.NR(10), .RD_REG(RD_REG_TB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running, want done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Reference GF helpers for the equivalent-inverse build.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [31:0] ref_imc(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            logic [7:0] x2, x4, x8;
            a[i]  = c[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Expected stored form of raw round key r.
    function automatic logic [127:0] ek(input int r, input logic [127:0] raw);
`ifdef AES_KS_EQINV_EN
        if (r >= 1 && r <= 9)
            return {ref_imc(raw[127:96]), ref_imc(raw[95:64]), ref_imc(raw[63:32]), ref_imc(raw[31:0])};
`endif
        return raw;
    endfunction

    // Registered-read scoreboard: expectation queued as the address is driven, compared on output.
    task automatic rd(input logic [3:0] a, input logic [127:0] exp, input string tag);
        logic [127:0] e;
        rk_addr = a;
        sb_q.push_back(exp);
        if (RD_REG_TB) @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(tag, rk_data, e);
    endtask

    // Offer key k (called at #1 after an edge, DUT idle). Optionally keep key_valid high
    // with key k2 throughout the expansion. Checks busy length and acceptance latency.
    task automatic expand(input logic [127:0] k, input bit hold, input logic [127:0] k2, input string tag);
        int n;
        int lows;
        key       = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) key = k2;
        else      key_valid = 1'b0;
        chk({tag, "_kv_drop"}, 128'(keys_valid), 128'(0));
        n    = 0;
        lows = (key_ready == 1'b0) ? 1 : 0;
        while (!keys_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!keys_valid && !key_ready) lows++;
        end
        key_valid = 1'b0;
        chk({tag, "_latency"}, 128'(n), 128'(10));
        chk({tag, "_busy_cycles"}, 128'(lows), 128'(10));
        chk({tag, "_ready_back"}, 128'(key_ready), 128'(1));
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key       = '0;
        rk_addr   = 4'd0;
        fips_rk[0]  = K1;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(key_ready), 128'(1));
        chk("rst_keys_valid", 128'(keys_valid), 128'(0));
        chk("rst_rk_data", rk_data, 128'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 key: full schedule
        expand(K1, 1'b0, '0, "k1");
        for (int r = 0; r <= 10; r++) rd(4'(r), ek(r, fips_rk[r]), $sformatf("k1_rk%0d", r));

        // Out-of-range indices read zero
        for (int a = 11; a <= 15; a++) rd(4'(a), 128'h0, $sformatf("oob_%0d", a));

        // Read latency: address change shows up one edge later (registered port)
        rk_addr = 4'd10;
        #1;
        chk("rd_lat_same_cycle", rk_data, RD_REG_TB ? 128'h0 : ek(10, fips_rk[10]));
        @(posedge clk);
        #1;
        chk("rd_lat_next_edge", rk_data, ek(10, fips_rk[10]));

        // Second key offered continuously during expansion must be ignored
        expand(K2, 1'b1, K1, "k2hold");
        rd(4'd0, K2, "k2_rk0");
        rd(4'd10, K2_RK10, "k2_rk10");

        // Re-key while keys_valid: rk10 read on its write edge returns the old value
        rk_addr = 4'd10;
        @(posedge clk);
        #1;
        expand(K1, 1'b0, '0, "rekey");
        chk("rdw_old_rk10", rk_data, K2_RK10);
        rd(4'd10, ek(10, fips_rk[10]), "rekey_rk10");
        rd(4'd1, ek(1, fips_rk[1]), "rekey_rk1");
        rd(4'd0, K1, "rekey_rk0");

        // Reset during expansion aborts everything
        key       = K2;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_key_ready", 128'(key_ready), 128'(1));
        chk("abort_keys_valid", 128'(keys_valid), 128'(0));
        chk("abort_rk_data", rk_data, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r <= 10; r++) rd(4'(r), 128'h0, $sformatf("abort_rk%0d", r));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
